// File: rtl/aes_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : aes_pkg                                                     |
// | Purpose  : Shared AES-128 constants, FSM state type and byte-level     |
// |            helpers (GF(2^8) multiply, S-box, round constant).          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_KEY_W  = 128;
  localparam int AES_NR     = 10;
  localparam int AES_NUM_RK = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } aes_state_t;

  typedef logic [3:0] aes_round_idx_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, which maps 0 to 0) plus the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for round-step select 0..9; unused selects give zero
  function automatic logic [7:0] rcon(input aes_round_idx_t idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expander_keygen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : aes_key_expander_keygen                                     |
// | Purpose  : Combinational single-round AES-128 key step: derives round  |
// |            key r+1 from round key r and the round-constant select.     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module aes_key_expander_keygen
  import aes_pkg::*;
(
  input  logic [3:0]           rc,
  input  logic [AES_KEY_W-1:0] key_cur,
  output logic [AES_KEY_W-1:0] key_next
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  // RotWord, SubWord and Rcon on the last word, then the xor chain across words
  always_comb begin
    w_w0   = key_cur[127:96];
    w_w1   = key_cur[95:64];
    w_w2   = key_cur[63:32];
    w_w3   = key_cur[31:0];
    w_temp = {sbox(w_w3[23:16]) ^ rcon(rc), sbox(w_w3[15:8]),
              sbox(w_w3[7:0]), sbox(w_w3[31:24])};
    w_n0   = w_w0 ^ w_temp;
    w_n1   = w_w1 ^ w_n0;
    w_n2   = w_w2 ^ w_n1;
    w_n3   = w_w3 ^ w_n2;
    key_next = {w_n0, w_n1, w_n2, w_n3};
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : aes_key_expander                                            |
// | Purpose  : Sequential AES-128 key schedule. Accepts a cipher key over  |
// |            valid/ready, expands one round per cycle into an 11-entry   |
// |            round-key register file with a registered read port.        |
// | Options  : `define AES_KEYEXP_ZEROIZE_EN adds a zeroize input that      |
// |            wipes all key material and returns to IDLE.                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int KEY_W      = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             keys_valid,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
);

  localparam int c_NUM_RK = AES_NUM_RK;

  aes_state_t     r_state;
  aes_round_idx_t r_rc;
  logic           r_key_ready;
  logic           r_keys_valid;
  logic [KEY_W-1:0] r_work;
  logic [KEY_W-1:0] r_rd_key;
  logic [KEY_W-1:0] r_rk [c_NUM_RK];
  logic [KEY_W-1:0] w_next;
  logic [KEY_W-1:0] w_rd_data;
  logic             w_wipe;

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign w_wipe = rst | zeroize;
`else
  assign w_wipe = rst;
`endif

  aes_key_expander_keygen u_keygen (
    .rc       (r_rc),
    .key_cur  (r_work),
    .key_next (w_next)
  );

  // Read mux; indices beyond the last round key return zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < c_NUM_RK; i++) begin
      if (rd_idx == aes_round_idx_t'(i)) w_rd_data = r_rk[i];
    end
  end

  // Control FSM, register file writes and registered read port
  always_ff @(posedge clk) begin
    if (w_wipe) begin
      r_state      <= IDLE;
      r_rc         <= '0;
      r_key_ready  <= 1'b1;
      r_keys_valid <= 1'b0;
      r_work       <= '0;
      r_rd_key     <= '0;
      for (int i = 0; i < c_NUM_RK; i++) r_rk[i] <= '0;
    end else begin
      // Non-blocking write below means a same-edge read sees the old entry
      if (rd_en) r_rd_key <= w_rd_data;

      case (r_state)
        IDLE, READY: begin
          if (key_valid && r_key_ready) begin
            r_rk[0]      <= key_in;
            r_work       <= key_in;
            r_rc         <= '0;
            r_state      <= EXPAND;
            r_key_ready  <= 1'b0;
            r_keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          for (int i = 1; i < c_NUM_RK; i++) begin
            if (r_rc == aes_round_idx_t'(i - 1)) r_rk[i] <= w_next;
          end
          r_work <= w_next;
          r_rc   <= r_rc + 4'd1;
          if (r_rc == aes_round_idx_t'(NUM_ROUNDS - 1)) begin
            r_state      <= READY;
            r_key_ready  <= 1'b1;
            r_keys_valid <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_key_ready  <= 1'b1;
          r_keys_valid <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready  = r_key_ready;
  assign keys_valid = r_keys_valid;
  assign rd_key     = r_rd_key;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_aes_key_expander                                         |
// | Purpose  : Self-checking bench for aes_key_expander with a word-level  |
// |            FIPS-197 key schedule model and a read-data scoreboard.     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`ifdef AES_KEYEXP_ZEROIZE_EN
  logic         zeroize;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  string        name_q[$];
  bit           rd_fire = 1'b0;

  logic [127:0] model_rk [11];
  logic [127:0] sched    [11];

  logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] RCON [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  aes_key_expander dut (
    .clk        (clk),
    .rst        (rst),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .keys_valid (keys_valid),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  // FIPS-197 word-oriented schedule: w[i] = w[i-4] ^ f(w[i-1]) over 44 words
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]] ^ RCON[i/4 - 1], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_of(input int idx);
    return (idx <= 10) ? model_rk[idx] : 128'h0;
  endfunction

  // Read-port monitor: a read accepted at an edge is compared at the next negedge
  always @(posedge clk) rd_fire = rd_en;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got rd_key %h expected no read", rd_key);
      end else begin
        chk(name_q.pop_front(), rd_key, exp_q.pop_front());
      end
    end
  end

  task automatic rd(input int idx, input logic [127:0] exp, input string nm);
    rd_en  = 1'b1;
    rd_idx = 4'(idx);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic read_all(input string nm);
    for (int i = 0; i < 16; i++) rd(i, exp_of(i), nm);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Load a key from IDLE/READY and follow the 10-cycle expansion.
  // rbw: read rk[0] on the accept edge and rk[1] on the first expand edge.
  // spam: pulse key_valid with a different key mid-expansion.
  task automatic load_key(input logic [127:0] k, input bit rbw, input bit spam);
    model_expand(k);
    chk("key_ready_pre", {127'h0, key_ready}, 128'h1);
    key_in    = k;
    key_valid = 1'b1;
    if (rbw) begin
      rd_en = 1'b1; rd_idx = 4'd0;
      exp_q.push_back(model_rk[0]); name_q.push_back("rbw_rk0");
    end
    @(negedge clk);
    key_valid = 1'b0;
    rd_en     = 1'b0;
    chk("accept_keys_valid", {127'h0, keys_valid}, 128'h0);
    chk("accept_key_ready", {127'h0, key_ready}, 128'h0);
    for (int e = 1; e <= 10; e++) begin
      if (rbw && e == 1) begin
        rd_en = 1'b1; rd_idx = 4'd1;
        exp_q.push_back(model_rk[1]); name_q.push_back("rbw_rk1");
      end
      key_valid = spam && (e >= 3) && (e <= 5);
      if (key_valid) key_in = rnd128();
      @(negedge clk);
      rd_en     = 1'b0;
      key_valid = 1'b0;
      if (e < 10) begin
        chk("expand_keys_valid", {127'h0, keys_valid}, 128'h0);
        chk("expand_key_ready", {127'h0, key_ready}, 128'h0);
      end else begin
        chk("done_keys_valid", {127'h0, keys_valid}, 128'h1);
        chk("done_key_ready", {127'h0, key_ready}, 128'h1);
      end
    end
    for (int r = 0; r < 11; r++) model_rk[r] = sched[r];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    rst = 1'b1; key_in = '0; key_valid = 1'b0; rd_en = 1'b0; rd_idx = '0;
`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    for (int r = 0; r < 11; r++) model_rk[r] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_key_ready", {127'h0, key_ready}, 128'h1);
    chk("rst_keys_valid", {127'h0, keys_valid}, 128'h0);
    chk("rst_rd_key", rd_key, 128'h0);
    read_all("rst_read");

    // FIPS-197 vector
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0);
    rd(1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
    rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
    @(negedge clk);
    chk("rd_hold", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "fips_rk0");
    read_all("fips_all");

    // Rekey in READY with the all-zero key, with read-before-write probes
    load_key(128'h0, 1'b1, 1'b0);
    rd(1,  128'h62636363626363636263636362636363, "zero_rk1");
    rd(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");
    rd(11, 128'h0, "zero_idx11");
    rd(15, 128'h0, "zero_idx15");

    // key_valid pulsed mid-expansion must be ignored
    load_key(rnd128(), 1'b0, 1'b1);
    read_all("spam_all");

    // Reset on the 5th expansion cycle aborts and clears storage
    k = rnd128();
    key_in = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_key_ready", {127'h0, key_ready}, 128'h1);
    chk("abort_keys_valid", {127'h0, keys_valid}, 128'h0);
    for (int r = 0; r < 11; r++) model_rk[r] = '0;
    read_all("abort_read");
    load_key(rnd128(), 1'b0, 1'b0);
    read_all("after_abort_all");

    // Random keys, back-to-back rekeys from READY
    for (int n = 0; n < 4; n++) begin
      load_key(rnd128(), n[0], 1'b0);
      for (int j = 0; j < 6; j++) begin
        int idx;
        idx = int'($urandom_range(0, 15));
        rd(idx, exp_of(idx), "rand_rd");
      end
    end

`ifdef AES_KEYEXP_ZEROIZE_EN
    // zeroize beats key_valid and rd_en on the same edge
    zeroize = 1'b1; key_valid = 1'b1; key_in = rnd128();
    rd_en = 1'b1; rd_idx = 4'd1;
    exp_q.push_back(128'h0); name_q.push_back("zero_rd_prio");
    @(negedge clk);
    zeroize = 1'b0; key_valid = 1'b0; rd_en = 1'b0;
    chk("zeroize_keys_valid", {127'h0, keys_valid}, 128'h0);
    chk("zeroize_key_ready", {127'h0, key_ready}, 128'h1);
    @(negedge clk);
    chk("zeroize_no_accept", {127'h0, key_ready}, 128'h1);
    for (int r = 0; r < 11; r++) model_rk[r] = '0;
    read_all("zeroize_read");
    load_key(rnd128(), 1'b0, 1'b0);
    read_all("after_zeroize_all");
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", 128'(exp_q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
